// File: rtl/schmidl_cox_peak_detector.sv
// Schmidl-Cox timing-metric peak detector: thresholds |P|^2 / R^2 and emits one peak index per run.
// Define SC_PEAK_PLATEAU_CENTER_EN to report the plateau centre instead of the max-numerator index.
module schmidl_cox_peak_detector #(
  parameter int FFT_SIZE  = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [15:0] threshold,
  input  logic [15:0] min_len,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready
);

  localparam int HOLD_W = (FFT_SIZE < 1) ? 1 : $clog2(FFT_SIZE + 1);

  typedef enum logic [1:0] {IDLE, RUN, EMIT, HOLDOFF} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] idx_cnt;
  logic                 s1_valid;
  logic                 s1_above;
  logic                 s1_last;
  logic [CNT_WIDTH-1:0] s1_idx;
  logic [15:0]          run_len;
  logic [HOLD_W-1:0]    holdoff;

  logic [15:0] num;
  logic [15:0] den;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic        above_now;

  assign num       = i_tdata[31:16];
  assign den       = i_tdata[15:0];
  assign lhs       = {1'b0, num, 15'b0};
  assign rhs       = {16'b0, threshold} * {16'b0, den};
  assign above_now = (lhs >= rhs) && (den != 16'd0);
  assign i_tready  = (state != EMIT);

`ifdef SC_PEAK_PLATEAU_CENTER_EN
  logic [CNT_WIDTH-1:0] start_idx;
`else
  logic [15:0]          s1_num;
  logic [15:0]          best_num;
  logic [CNT_WIDTH-1:0] best_idx;
`endif

  // Stage 1 only advances when the FSM can consume, so a beat parked during EMIT is kept.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_above <= 1'b0;
      s1_last  <= 1'b0;
      s1_idx   <= '0;
`ifndef SC_PEAK_PLATEAU_CENTER_EN
      s1_num   <= '0;
`endif
    end else if (i_tready) begin
      s1_valid <= i_tvalid;
      if (i_tvalid) begin
        s1_above <= above_now;
        s1_last  <= i_tlast;
        s1_idx   <= idx_cnt;
`ifndef SC_PEAK_PLATEAU_CENTER_EN
        s1_num   <= num;
`endif
        idx_cnt  <= i_tlast ? '0 : idx_cnt + 1'b1;
      end
    end
  end

  logic [15:0]          len_inc;
  logic [15:0]          final_len;
  logic [15:0]          min_eff;
  logic                 run_done;
  logic [CNT_WIDTH-1:0] peak_idx;

  assign len_inc   = (run_len == 16'hFFFF) ? run_len : run_len + 16'd1;
  assign final_len = s1_above ? len_inc : run_len;
  assign min_eff   = (min_len == 16'd0) ? 16'd1 : min_len;
  assign run_done  = s1_above ? s1_last : 1'b1;

`ifdef SC_PEAK_PLATEAU_CENTER_EN
  assign peak_idx = start_idx + CNT_WIDTH'(final_len >> 1);
`else
  // The run-ending beat may itself be the new maximum when it closes the run via tlast.
  assign peak_idx = (s1_above && (s1_num > best_num)) ? s1_idx : best_idx;
`endif

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state     <= IDLE;
      run_len   <= '0;
      holdoff   <= '0;
      o_tvalid  <= 1'b0;
      o_tlast   <= 1'b0;
      o_tdata   <= '0;
`ifdef SC_PEAK_PLATEAU_CENTER_EN
      start_idx <= '0;
`else
      best_num  <= '0;
      best_idx  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (s1_valid && s1_above) begin
            run_len   <= 16'd1;
`ifdef SC_PEAK_PLATEAU_CENTER_EN
            start_idx <= s1_idx;
`else
            best_num  <= s1_num;
            best_idx  <= s1_idx;
`endif
            state     <= RUN;
          end
        end
        RUN: begin
          if (s1_valid) begin
            if (s1_above) begin
              run_len <= len_inc;
`ifndef SC_PEAK_PLATEAU_CENTER_EN
              if (s1_num > best_num) begin
                best_num <= s1_num;
                best_idx <= s1_idx;
              end
`endif
            end
            if (run_done) begin
              if (final_len >= min_eff) begin
                o_tvalid <= 1'b1;
                o_tlast  <= 1'b1;
                o_tdata  <= 32'(peak_idx);
                state    <= EMIT;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        EMIT: begin
          if (o_tready) begin
            o_tvalid <= 1'b0;
            o_tlast  <= 1'b0;
            holdoff  <= HOLD_W'(FFT_SIZE);
            state    <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          // Blanks one symbol after a peak so the metric plateau tail cannot retrigger.
          if (s1_valid) begin
            holdoff <= holdoff - 1'b1;
            if (holdoff <= HOLD_W'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_schmidl_cox_peak_detector.sv
// Directed testbench for schmidl_cox_peak_detector (FFT_SIZE=4, threshold 0.5, min_len 3).
module tb_schmidl_cox_peak_detector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] threshold = 16'h4000;
  logic [15:0] min_len = 16'd3;
  logic [31:0] i_tdata = '0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;

  int total = 0;
  int bad = 0;

  int          ev_count = 0;
  logic [31:0] ev_data [16];
  logic        ev_last [16];
  logic        ready_dropped = 1'b0;

  schmidl_cox_peak_detector #(.FFT_SIZE(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .clear(clear), .threshold(threshold), .min_len(min_len),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  always #5 clk = ~clk;

  // Event log of completed output handshakes, wiped by reset.
  always @(negedge clk) begin
    if (reset || clear) begin
      ev_count      = 0;
      ready_dropped = 1'b0;
    end else begin
      if (o_tvalid && o_tready) begin
        if (ev_count < 16) begin
          ev_data[ev_count] = o_tdata;
          ev_last[ev_count] = o_tlast;
        end
        ev_count++;
      end
      if (!i_tready) ready_dropped = 1'b1;
    end
  end

  task automatic do_reset();
    reset     = 1'b1;
    i_tvalid  = 1'b0;
    i_tlast   = 1'b0;
    o_tready  = 1'b1;
    threshold = 16'h4000;
    min_len   = 16'd3;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] num, input logic [15:0] den, input logic last);
    int n;
    i_tdata  = {num, den};
    i_tlast  = last;
    i_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!i_tready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!i_tready) begin
      total++; bad++;
      $display("[TB] FAIL input_accept_timeout: i_tready=%0b required 1", i_tready);
    end
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic wait_events(input int n, input string name);
    int k;
    k = 0;
    while (ev_count < n && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    total++;
    if (ev_count < n) begin
      bad++;
      $display("[TB] FAIL %s_event_timeout: events=%0d required %0d", name, ev_count, n);
    end
  endtask

  task automatic send_single_run();
    send_beat(16'd0, 16'd100, 1'b0);
    send_beat(16'd0, 16'd100, 1'b0);
    send_beat(16'd60, 16'd100, 1'b0);
    send_beat(16'd80, 16'd100, 1'b0);
    send_beat(16'd70, 16'd100, 1'b0);
    send_beat(16'd0, 16'd100, 1'b0);
  endtask

  // Indices 7..13: 7-9 must fall in holdoff, 10-12 form the next run peaking at 11.
  task automatic send_holdoff_tail();
    for (int i = 7; i <= 9; i++) send_beat(16'd200, 16'd100, 1'b0);
    send_beat(16'd60, 16'd100, 1'b0);
    send_beat(16'd90, 16'd100, 1'b0);
    send_beat(16'd70, 16'd100, 1'b0);
    send_beat(16'd0, 16'd100, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    total += 4;
    if (o_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_o_tvalid: got %0b required 0", o_tvalid); end
    if (o_tdata !== 32'd0) begin bad++; $display("[TB] FAIL reset_o_tdata: got %0d required 0", o_tdata); end
    if (o_tlast !== 1'b0) begin bad++; $display("[TB] FAIL reset_o_tlast: got %0b required 0", o_tlast); end
    if (i_tready !== 1'b1) begin bad++; $display("[TB] FAIL reset_i_tready: got %0b required 1", i_tready); end
  endtask

  task automatic test_single_run();
    do_reset();
    send_single_run();
    total++;
    if (o_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL single_early_valid: got %0b required 0", o_tvalid); end
    @(posedge clk); #1;
    total += 3;
    if (o_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL single_latency_valid: got %0b required 1", o_tvalid); end
    if (o_tdata !== 32'd3) begin bad++; $display("[TB] FAIL single_data: got %0d required 3", o_tdata); end
    if (o_tlast !== 1'b1) begin bad++; $display("[TB] FAIL single_tlast: got %0b required 1", o_tlast); end
    repeat (8) @(posedge clk);
    #1;
    total += 3;
    if (ev_count !== 1) begin bad++; $display("[TB] FAIL single_event_count: got %0d required 1", ev_count); end
    if (ev_data[0] !== 32'd3) begin bad++; $display("[TB] FAIL single_logged_data: got %0d required 3", ev_data[0]); end
    if (ev_last[0] !== 1'b1) begin bad++; $display("[TB] FAIL single_logged_tlast: got %0b required 1", ev_last[0]); end
  endtask

  task automatic test_short_run();
    do_reset();
    send_beat(16'd0, 16'd100, 1'b0);
    send_beat(16'd60, 16'd100, 1'b0);
    send_beat(16'd60, 16'd100, 1'b0);
    send_beat(16'd0, 16'd100, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    total += 2;
    if (ev_count !== 0) begin bad++; $display("[TB] FAIL short_event_count: got %0d required 0", ev_count); end
    if (ready_dropped !== 1'b0) begin bad++; $display("[TB] FAIL short_ready_dropped: got %0b required 0", ready_dropped); end
  endtask

  task automatic test_holdoff();
    do_reset();
    send_single_run();
    send_beat(16'd200, 16'd100, 1'b0);
    send_holdoff_tail();
    wait_events(2, "holdoff");
    repeat (8) @(posedge clk);
    #1;
    total += 3;
    if (ev_count !== 2) begin bad++; $display("[TB] FAIL holdoff_event_count: got %0d required 2", ev_count); end
    if (ev_data[0] !== 32'd3) begin bad++; $display("[TB] FAIL holdoff_first: got %0d required 3", ev_data[0]); end
    if (ev_data[1] !== 32'd11) begin bad++; $display("[TB] FAIL holdoff_second: got %0d required 11", ev_data[1]); end
  endtask

  task automatic test_backpressure();
    do_reset();
    o_tready = 1'b0;
    send_single_run();
    send_beat(16'd200, 16'd100, 1'b0);
    for (int c = 0; c < 5; c++) begin
      total += 3;
      if (o_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid[%0d]: got %0b required 1", c, o_tvalid); end
      if (o_tdata !== 32'd3) begin bad++; $display("[TB] FAIL stall_data[%0d]: got %0d required 3", c, o_tdata); end
      if (i_tready !== 1'b0) begin bad++; $display("[TB] FAIL stall_ready[%0d]: got %0b required 0", c, i_tready); end
      @(posedge clk); #1;
    end
    o_tready = 1'b1;
    send_holdoff_tail();
    wait_events(2, "backpressure");
    repeat (8) @(posedge clk);
    #1;
    total += 3;
    if (ev_count !== 2) begin bad++; $display("[TB] FAIL bp_event_count: got %0d required 2", ev_count); end
    if (ev_data[0] !== 32'd3) begin bad++; $display("[TB] FAIL bp_first: got %0d required 3", ev_data[0]); end
    if (ev_data[1] !== 32'd11) begin bad++; $display("[TB] FAIL bp_second: got %0d required 11", ev_data[1]); end
  endtask

  task automatic test_edge_arith();
    logic [31:0] exp_unity;
`ifdef SC_PEAK_PLATEAU_CENTER_EN
    exp_unity = 32'd2;
`else
    exp_unity = 32'd1;
`endif
    // Zero denominator never qualifies, however large the numerator.
    do_reset();
    for (int i = 0; i < 4; i++) send_beat(16'hFFFF, 16'd0, 1'b0);
    send_beat(16'd0, 16'd100, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (ev_count !== 0) begin bad++; $display("[TB] FAIL den_zero_events: got %0d required 0", ev_count); end

    // Unity threshold with num == den sits exactly on the boundary and counts as above.
    do_reset();
    threshold = 16'h8000;
    send_beat(16'd0, 16'd200, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(16'd200, 16'd200, 1'b0);
    send_beat(16'd0, 16'd200, 1'b0);
    wait_events(1, "unity");
    total++;
    if (ev_data[0] !== exp_unity) begin bad++; $display("[TB] FAIL unity_data: got %0d required %0d", ev_data[0], exp_unity); end

    // tlast closes the run on its own beat and restarts the index at 0.
    do_reset();
    send_beat(16'd0, 16'd100, 1'b0);
    send_beat(16'd60, 16'd100, 1'b0);
    send_beat(16'd80, 16'd100, 1'b0);
    send_beat(16'd70, 16'd100, 1'b1);
    for (int i = 0; i < 4; i++) send_beat(16'd0, 16'd100, 1'b0);
    send_beat(16'd60, 16'd100, 1'b0);
    send_beat(16'd90, 16'd100, 1'b0);
    send_beat(16'd60, 16'd100, 1'b0);
    send_beat(16'd0, 16'd100, 1'b0);
    wait_events(2, "tlast");
    total += 2;
    if (ev_data[0] !== 32'd2) begin bad++; $display("[TB] FAIL tlast_first: got %0d required 2", ev_data[0]); end
    if (ev_data[1] !== 32'd5) begin bad++; $display("[TB] FAIL tlast_index_restart: got %0d required 5", ev_data[1]); end
  endtask

  task automatic test_reset_mid_emit();
    int k;
    do_reset();
    o_tready = 1'b0;
    send_single_run();
    k = 0;
    while (!o_tvalid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    total++;
    if (o_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL abort_pre_valid: got %0b required 1", o_tvalid); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total += 2;
    if (o_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL abort_valid: got %0b required 0", o_tvalid); end
    if (i_tready !== 1'b1) begin bad++; $display("[TB] FAIL abort_ready: got %0b required 1", i_tready); end
    o_tready = 1'b1;
    send_beat(16'd0, 16'd100, 1'b0);
    send_beat(16'd60, 16'd100, 1'b0);
    send_beat(16'd80, 16'd100, 1'b0);
    send_beat(16'd70, 16'd100, 1'b0);
    send_beat(16'd0, 16'd100, 1'b0);
    wait_events(1, "abort");
    total++;
    if (ev_data[0] !== 32'd2) begin bad++; $display("[TB] FAIL abort_index_restart: got %0d required 2", ev_data[0]); end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_short_run();
    test_holdoff();
    test_backpressure();
    test_edge_arith();
    test_reset_mid_emit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
